// File: rtl/bpb_pkg.sv
// Shared types and helpers for the branch prediction buffer: entry layout,
// 2-bit counter encodings and the PC-to-tag mapping.
package bpb_pkg;

  localparam int PC_TAG_W = 30;

  typedef logic [1:0] ctr_t;

  localparam ctr_t SNT = 2'b00;
  localparam ctr_t WNT = 2'b01;
  localparam ctr_t WT  = 2'b10;
  localparam ctr_t ST  = 2'b11;

  typedef struct packed {
    logic                valid;
    logic [PC_TAG_W-1:0] tag;
    logic [31:0]         target;
    ctr_t                ctr;
  } entry_t;

  function automatic logic [PC_TAG_W-1:0] to_tag(input logic [31:0] pc);
    return pc[31:2];
  endfunction

  function automatic ctr_t ctr_inc(input ctr_t c);
    return (c == ST) ? ST : c + 2'd1;
  endfunction

  function automatic ctr_t ctr_dec(input ctr_t c);
    return (c == SNT) ? SNT : c - 2'd1;
  endfunction

endpackage

// File: rtl/bpb_victim_sel.sv
// Allocation victim picker: lowest-index invalid entry if any, otherwise the
// round-robin slot. The caller owns and advances the pointer.
module bpb_victim_sel #(
  parameter int ENTRIES = 16,
  parameter int IDX_W   = $clog2(ENTRIES)
) (
  input  logic [ENTRIES-1:0] valid_i,
  input  logic [IDX_W-1:0]   rr_ptr_i,
  output logic [IDX_W-1:0]   victim_idx_o,
  output logic               use_rr_o
);

  always_comb begin
    victim_idx_o = rr_ptr_i;
    use_rr_o     = 1'b1;
    // Scan downward so the last assignment wins with the lowest free index.
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      if (!valid_i[i]) begin
        victim_idx_o = IDX_W'(i);
        use_rr_o     = 1'b0;
      end
    end
  end

endmodule

// File: rtl/bpb_table.sv
// Fully-associative branch prediction buffer with combinational fetch lookup,
// execute-stage write-back, allocation/eviction and perf counters.
module bpb_table
  import bpb_pkg::*;
#(
  parameter int ENTRIES   = 16,
  parameter int TAG_WIDTH = PC_TAG_W
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] pc_f,
  output logic        pred_hit,
  output logic        pred_taken,
  output logic [31:0] pred_target,
  input  logic        upd_valid,
  input  logic [31:0] upd_pc,
  input  logic        upd_taken,
  input  logic [31:0] upd_target,
  input  logic        flush_table,
  output logic [31:0] n_updates,
  output logic [31:0] n_mispredicts
);

  localparam int IDX_W = $clog2(ENTRIES);

  entry_t             table_q [ENTRIES];
  entry_t             table_d [ENTRIES];
  logic [IDX_W-1:0]   rr_q, rr_d;
  logic [31:0]        n_upd_q, n_upd_d;
  logic [31:0]        n_mis_q, n_mis_d;

  logic [TAG_WIDTH-1:0] f_tag, u_tag;
  logic                 f_hit, u_hit;
  logic [IDX_W-1:0]     f_idx, u_idx;
  logic [ENTRIES-1:0]   valid_vec;
  logic [IDX_W-1:0]     victim_idx;
  logic                 use_rr;
  logic                 mispredict;
  logic                 unused_pc_lsbs;

  assign unused_pc_lsbs = ^upd_pc[1:0];

  assign f_tag = to_tag(pc_f);
  assign u_tag = to_tag(upd_pc);

  // Two independent match ports; allocation only on miss keeps each one-hot.
  always_comb begin
    f_hit     = 1'b0;
    f_idx     = '0;
    u_hit     = 1'b0;
    u_idx     = '0;
    valid_vec = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      valid_vec[i] = table_q[i].valid;
      if (table_q[i].valid && table_q[i].tag == f_tag) begin
        f_hit = 1'b1;
        f_idx = IDX_W'(i);
      end
      if (table_q[i].valid && table_q[i].tag == u_tag) begin
        u_hit = 1'b1;
        u_idx = IDX_W'(i);
      end
    end
  end

  assign pred_hit    = f_hit;
  assign pred_taken  = f_hit & table_q[f_idx].ctr[1];
  assign pred_target = pred_taken ? table_q[f_idx].target : pc_f + 32'd4;

  bpb_victim_sel #(
    .ENTRIES (ENTRIES),
    .IDX_W   (IDX_W)
  ) u_victim_sel (
    .valid_i      (valid_vec),
    .rr_ptr_i     (rr_q),
    .victim_idx_o (victim_idx),
    .use_rr_o     (use_rr)
  );

  always_comb begin
    mispredict = ((u_hit & table_q[u_idx].ctr[1]) != upd_taken) ||
                 (upd_taken && u_hit && table_q[u_idx].ctr[1] &&
                  table_q[u_idx].target != upd_target);
  end

  always_comb begin
    table_d = table_q;
    rr_d    = rr_q;
    n_upd_d = n_upd_q;
    n_mis_d = n_mis_q;
    if (flush_table) begin
      for (int i = 0; i < ENTRIES; i++) begin
        table_d[i].valid = 1'b0;
        table_d[i].ctr   = SNT;
      end
      rr_d = '0;
    end else if (upd_valid) begin
      n_upd_d = n_upd_q + 32'd1;
      if (mispredict) n_mis_d = n_mis_q + 32'd1;
      if (u_hit) begin
        if (upd_taken) begin
          table_d[u_idx].ctr    = ctr_inc(table_q[u_idx].ctr);
          table_d[u_idx].target = upd_target;
        end else begin
          table_d[u_idx].ctr = ctr_dec(table_q[u_idx].ctr);
        end
      end else if (upd_taken) begin
        table_d[victim_idx] = '{valid: 1'b1, tag: u_tag, target: upd_target, ctr: WT};
        if (use_rr) rr_d = rr_q + 1'b1;
      end
    end
  end

  // NOTE: the whole array is reset because a stale tag with a cleared valid
  // bit is harmless, but a reset value on every field keeps simulation X-free.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < ENTRIES; i++) table_q[i] <= '0;
      rr_q    <= '0;
      n_upd_q <= '0;
      n_mis_q <= '0;
    end else begin
      table_q <= table_d;
      rr_q    <= rr_d;
      n_upd_q <= n_upd_d;
      n_mis_q <= n_mis_d;
    end
  end

  assign n_updates     = n_upd_q;
  assign n_mispredicts = n_mis_q;

endmodule

// File: tb/tb_bpb_table.sv
// Directed bench for bpb_table: counter saturation, mispredict accounting,
// round-robin eviction, same-cycle no-bypass, flush priority and reset.
module tb_bpb_table;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] pc_f;
  logic        pred_hit, pred_taken;
  logic [31:0] pred_target;
  logic        upd_valid;
  logic [31:0] upd_pc;
  logic        upd_taken;
  logic [31:0] upd_target;
  logic        flush_table;
  logic [31:0] n_updates, n_mispredicts;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  bpb_table #(.ENTRIES(16), .TAG_WIDTH(30)) dut (
    .clk           (clk),
    .reset         (reset),
    .pc_f          (pc_f),
    .pred_hit      (pred_hit),
    .pred_taken    (pred_taken),
    .pred_target   (pred_target),
    .upd_valid     (upd_valid),
    .upd_pc        (upd_pc),
    .upd_taken     (upd_taken),
    .upd_target    (upd_target),
    .flush_table   (flush_table),
    .n_updates     (n_updates),
    .n_mispredicts (n_mispredicts)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Apply one resolved branch for a single cycle.
  task automatic update(input logic [31:0] pc, input logic taken, input logic [31:0] tgt);
    upd_valid  = 1'b1;
    upd_pc     = pc;
    upd_taken  = taken;
    upd_target = tgt;
    tick();
    upd_valid  = 1'b0;
  endtask

  task automatic look(input string tag, input logic [31:0] pc,
                      input logic hit, input logic tkn, input logic [31:0] tgt);
    pc_f = pc;
    #1;
    check({tag, ".hit"},    {31'd0, pred_hit},   {31'd0, hit});
    check({tag, ".taken"},  {31'd0, pred_taken}, {31'd0, tkn});
    check({tag, ".target"}, pred_target,         tgt);
  endtask

  task automatic counts(input string tag, input logic [31:0] upd, input logic [31:0] mis);
    check({tag, ".n_upd"}, n_updates,     upd);
    check({tag, ".n_mis"}, n_mispredicts, mis);
  endtask

  initial begin
    reset = 1'b1; pc_f = 32'h0; upd_valid = 1'b0; upd_pc = 32'h0;
    upd_taken = 1'b0; upd_target = 32'h0; flush_table = 1'b0;
    tick(); tick();
    reset = 1'b0;

    look("rst", 32'h100, 1'b0, 1'b0, 32'h104);
    counts("rst", 0, 0);
    look("wrap", 32'hFFFF_FFFC, 1'b0, 1'b0, 32'h0);

    // Allocate weakly taken.
    update(32'h100, 1'b1, 32'h200);
    look("alloc", 32'h100, 1'b1, 1'b1, 32'h200);
    counts("alloc", 1, 1);

    // 10 -> 01 (mispredict) -> 00 -> 00.
    update(32'h100, 1'b0, 32'h0);
    look("nt1", 32'h100, 1'b1, 1'b0, 32'h104);
    update(32'h100, 1'b0, 32'h0);
    update(32'h100, 1'b0, 32'h0);
    look("nt3", 32'h100, 1'b1, 1'b0, 32'h104);
    counts("nt3", 4, 2);

    // 00 -> 01: still not taken, proves 00 held.
    update(32'h100, 1'b1, 32'h200);
    look("sat0", 32'h100, 1'b1, 1'b0, 32'h104);
    // 01 -> 10 -> 11, then NT -> 10 stays taken, proves 11 held.
    update(32'h100, 1'b1, 32'h200);
    update(32'h100, 1'b1, 32'h200);
    update(32'h100, 1'b0, 32'h0);
    look("sat3", 32'h100, 1'b1, 1'b1, 32'h200);
    counts("sat3", 8, 5);

    // Correct direction, wrong target is a mispredict; target refreshed.
    update(32'h100, 1'b1, 32'h280);
    look("tgt", 32'h100, 1'b1, 1'b1, 32'h280);
    counts("tgt", 9, 6);

    // Fill entries 1..15 (0x100 sits in entry 0).
    for (int i = 1; i < 16; i++) update(32'h1000 + 32'(4 * i), 1'b1, 32'h2000 + 32'(i));
    look("full", 32'h103C, 1'b1, 1'b1, 32'h200F);
    counts("full", 24, 21);

    // 17th evicts entry 0, 18th evicts entry 1.
    update(32'h5000, 1'b1, 32'h6000);
    look("ev0.old", 32'h100,  1'b0, 1'b0, 32'h104);
    look("ev0.new", 32'h5000, 1'b1, 1'b1, 32'h6000);
    look("ev0.e1",  32'h1004, 1'b1, 1'b1, 32'h2001);
    update(32'h5004, 1'b1, 32'h6004);
    look("ev1.old", 32'h1004, 1'b0, 1'b0, 32'h1008);
    look("ev1.e2",  32'h1008, 1'b1, 1'b1, 32'h2002);
    counts("ev1", 26, 23);

    // Same-cycle lookup and update: no bypass.
    pc_f = 32'h300; upd_valid = 1'b1; upd_pc = 32'h300; upd_taken = 1'b1; upd_target = 32'h400;
    #1;
    check("same.pre_hit", {31'd0, pred_hit}, 32'd0);
    tick();
    upd_valid = 1'b0;
    look("same.post", 32'h300, 1'b1, 1'b1, 32'h400);
    look("same.ev2",  32'h1008, 1'b0, 1'b0, 32'h100C);
    counts("same", 27, 24);

    // Flush wins over a same-cycle update.
    flush_table = 1'b1;
    update(32'h600, 1'b1, 32'h700);
    flush_table = 1'b0;
    look("fl.300",  32'h300,  1'b0, 1'b0, 32'h304);
    look("fl.600",  32'h600,  1'b0, 1'b0, 32'h604);
    look("fl.5000", 32'h5000, 1'b0, 1'b0, 32'h5004);
    counts("fl", 27, 24);
    update(32'h700, 1'b1, 32'h800);
    look("fl.realloc", 32'h700, 1'b1, 1'b1, 32'h800);

    // Reset mid-stream drops the concurrent update and clears everything.
    reset = 1'b1;
    update(32'h900, 1'b1, 32'hA00);
    reset = 1'b0;
    look("mrst.700", 32'h700, 1'b0, 1'b0, 32'h704);
    look("mrst.900", 32'h900, 1'b0, 1'b0, 32'h904);
    counts("mrst", 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
